// File: rtl/rej_sample_ctrl.sv
// ============================================================================
// Module   : rej_sample_ctrl
// Brief    : Rejection-sampling sequencer around a 6-wide-write / 1-wide-read
//            coefficient FIFO; emits N accepted coefficients then pulses done.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rej_sample_ctrl #(
    parameter int N     = 256,
    parameter int Q     = 3329,
    parameter int CNT_W = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [71:0]                         in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                fifo_w_en,
    output logic [71:0]                         fifo_data,
    output logic [5:0]                          fifo_valid,
    input  logic                                fifo_full,
    input  logic                                fifo_empty,
    output logic                                fifo_r_en,
    input  logic [11:0]                         fifo_dout,
    input  logic                                fifo_vout,
    output logic                                fifo_clr,
    output logic [11:0]                         coef,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] coef_idx,
    output logic                                coef_valid,
    output logic                                busy,
    output logic                                done,
    output logic [CNT_W-1:0]                    rej_cnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_rej_cnt;
    logic [11:0]        r_coef;
    logic [IDX_W-1:0]   r_coef_idx;
    logic               r_coef_valid;
    logic               w_run;
    logic               w_accept;
    logic               w_last;
    logic [2:0]         w_rej_lanes;
    logic [CNT_W:0]     w_rej_sum;
    logic [5:0]         w_lane_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_lane
            assign w_lane_ok[gi] = (in_data[12*gi +: 12] < 12'(Q));
        end
    endgenerate

    assign w_run      = (r_state == S_RUN);
    assign in_ready   = w_run & ~fifo_full;
    assign fifo_w_en  = in_valid & in_ready;
    assign fifo_data  = in_data;
    assign fifo_valid = w_lane_ok;
    assign fifo_r_en  = w_run & ~fifo_empty;
    assign fifo_clr   = rst | (r_state == S_CLR);
    assign busy       = (r_state == S_CLR) | w_run;
    assign done       = (r_state == S_DONE);

    // Returns arriving after the run has left RUN are silently discarded.
    assign w_accept = w_run & fifo_vout & (r_acc < ACC_W'(N));
    assign w_last   = (r_acc == ACC_W'(N - 1));

    always_comb begin
        w_rej_lanes = 3'd0;
        for (int i = 0; i < 6; i++) begin
            w_rej_lanes = w_rej_lanes + {2'b00, ~w_lane_ok[i]};
        end
    end

    assign w_rej_sum = {1'b0, r_rej_cnt} + (CNT_W+1)'(w_rej_lanes);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CLR;
            S_CLR:   w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_CLR : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_rej_cnt    <= '0;
            r_coef       <= '0;
            r_coef_idx   <= '0;
            r_coef_valid <= 1'b0;
        end else begin
            r_coef_valid <= 1'b0;
            if (w_state_nxt == S_CLR) begin
                r_acc     <= '0;
                r_rej_cnt <= '0;
            end else begin
                if (fifo_w_en) begin
                    r_rej_cnt <= w_rej_sum[CNT_W] ? {CNT_W{1'b1}} : w_rej_sum[CNT_W-1:0];
                end
                if (w_accept) begin
                    r_coef       <= fifo_dout;
                    r_coef_idx   <= r_acc[IDX_W-1:0];
                    r_coef_valid <= 1'b1;
                    r_acc        <= r_acc + ACC_W'(1);
                end
            end
        end
    end

    assign coef       = r_coef;
    assign coef_idx   = r_coef_idx;
    assign coef_valid = r_coef_valid;
    assign rej_cnt    = r_rej_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rej_sample_ctrl.sv
// ============================================================================
// Module   : tb_rej_sample_ctrl
// Brief    : Directed self-checking bench for rej_sample_ctrl with a small
//            behavioural FIFO attached.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rej_sample_ctrl;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [71:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        fifo_w_en;
    logic [71:0] fifo_data;
    logic [5:0]  fifo_valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_r_en;
    logic [11:0] fifo_dout = '0;
    logic        fifo_vout = 1'b0;
    logic        fifo_clr;
    logic [11:0] coef;
    logic [7:0]  coef_idx;
    logic        coef_valid;
    logic        busy;
    logic        done;
    logic [15:0] rej_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rej_sample_ctrl #(.N(256), .Q(3329), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_w_en  (fifo_w_en),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_dout  (fifo_dout),
        .fifo_vout  (fifo_vout),
        .fifo_clr   (fifo_clr),
        .coef       (coef),
        .coef_idx   (coef_idx),
        .coef_valid (coef_valid),
        .busy       (busy),
        .done       (done),
        .rej_cnt    (rej_cnt)
    );

    // Behavioural FIFO: 6 entries in per write (lane 0 first), 1 out per read.
    logic [12:0] mem [DEPTH];
    int          wp = 0;
    int          rp = 0;
    int          cnt = 0;
    logic        force_full = 1'b0;

    assign fifo_full  = force_full | (cnt > DEPTH - 6);
    assign fifo_empty = (cnt == 0);

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp        <= 0;
            rp        <= 0;
            cnt       <= 0;
            fifo_dout <= '0;
            fifo_vout <= 1'b0;
        end else begin
            fifo_vout <= 1'b0;
            if (fifo_r_en) begin
                fifo_dout <= mem[rp][11:0];
                fifo_vout <= mem[rp][12];
                rp        <= (rp + 1) % DEPTH;
            end
            if (fifo_w_en) begin
                for (int i = 0; i < 6; i++) begin
                    mem[(wp + i) % DEPTH] <= {fifo_valid[i], fifo_data[12*i +: 12]};
                end
                wp <= (wp + 6) % DEPTH;
            end
            cnt <= cnt + (fifo_w_en ? 6 : 0) - (fifo_r_en ? 1 : 0);
        end
    end

    int got_coef[$];
    int got_idx[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (coef_valid) begin
            got_coef.push_back(int'(coef));
            got_idx.push_back(int'(coef_idx));
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [71:0] d);
        int t;
        t        = 0;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 1000) check("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("wait_done_timeout", 32'(done), 32'd1);
    endtask

    // Every accepted coefficient must follow lane pattern 1..6 with idx k.
    task automatic check_full_run(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < got_coef.size(); k++) begin
            if (got_idx[k] != k || got_coef[k] != (k % 6) + 1) bad++;
        end
        check({tag, "_count"}, 32'(got_coef.size()), 32'd256);
        check({tag, "_seq_bad"}, 32'(bad), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    localparam logic [71:0] BUNDLE_A = {12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001};
    localparam logic [71:0] BUNDLE_B = {12'h7FF, 12'hD02, 12'h000, 12'hFFF, 12'hD00, 12'hD01};
    localparam logic [71:0] BUNDLE_C = {12'h015, 12'h014, 12'h013, 12'h012, 12'h011, 12'h010};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int t;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // T1: reset state
        cyc(2);
        in_valid = 1'b1;
        start    = 1'b1;
        #1;
        check("t1_busy",       32'(busy),       32'd0);
        check("t1_done",       32'(done),       32'd0);
        check("t1_in_ready",   32'(in_ready),   32'd0);
        check("t1_fifo_w_en",  32'(fifo_w_en),  32'd0);
        check("t1_fifo_r_en",  32'(fifo_r_en),  32'd0);
        check("t1_fifo_clr",   32'(fifo_clr),   32'd1);
        check("t1_rej_cnt",    32'(rej_cnt),    32'd0);
        check("t1_coef_valid", 32'(coef_valid), 32'd0);
        @(negedge clk);
        check("t1_rst_beats_start", 32'(busy), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        check("t1_clr_released", 32'(fifo_clr), 32'd0);

        // T2: full run of all-accepted lanes
        got_coef.delete();
        got_idx.delete();
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t2_clr", 32'(fifo_clr), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        for (int b = 0; b < 43; b++) send(BUNDLE_A);
        wait_done();
        check("t2_done_in_ready", 32'(in_ready), 32'd0);
        check("t2_done_r_en", 32'(fifo_r_en), 32'd0);
        cyc(10);
        check_full_run("t2");
        check("t2_rej_cnt", 32'(rej_cnt), 32'd0);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // T3: boundary lanes around Q
        got_coef.delete();
        got_idx.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_clr", 32'(fifo_clr), 32'd1);
        @(negedge clk);
        check("t3_clr_one_cycle", 32'(fifo_clr), 32'd0);
        in_data = BUNDLE_B;
        #1;
        check("t3_fifo_valid", 32'(fifo_valid), 32'b101010);
        send(BUNDLE_B);
        cyc(12);
        check("t3_rej_cnt", 32'(rej_cnt), 32'd3);
        check("t3_count", 32'(got_coef.size()), 32'd3);
        if (got_coef.size() >= 3) begin
            check("t3_coef0", 32'(got_coef[0]), 32'h0D00);
            check("t3_coef1", 32'(got_coef[1]), 32'h0000);
            check("t3_coef2", 32'(got_coef[2]), 32'h07FF);
            check("t3_idx2",  32'(got_idx[2]),  32'd2);
        end

        // T4: backpressure from a full FIFO
        force_full = 1'b1;
        in_data    = BUNDLE_C;
        in_valid   = 1'b1;
        bad        = 0;
        repeat (20) begin
            #1;
            if (in_ready || fifo_w_en) bad++;
            @(negedge clk);
        end
        check("t4_blocked", 32'(bad), 32'd0);
        force_full = 1'b0;
        #1;
        check("t4_resume_ready", 32'(in_ready), 32'd1);
        check("t4_resume_w_en", 32'(fifo_w_en), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc(12);
        check("t4_count", 32'(got_coef.size()), 32'd9);
        if (got_coef.size() >= 9) begin
            check("t4_coef3", 32'(got_coef[3]), 32'h010);
            check("t4_coef8", 32'(got_coef[8]), 32'h015);
            check("t4_idx8",  32'(got_idx[8]),  32'd8);
        end
        check("t4_rej_cnt", 32'(rej_cnt), 32'd3);

        // T5: reset in the middle of a run
        in_data  = BUNDLE_C;
        in_valid = 1'b1;
        t = 0;
        while (!(coef_valid && coef_idx == 8'd100) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("t5_reach_idx100", {23'd0, coef_valid, coef_idx}, {23'd0, 1'b1, 8'd100});
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_busy",       32'(busy),       32'd0);
        check("t5_coef_valid", 32'(coef_valid), 32'd0);
        check("t5_coef_idx",   32'(coef_idx),   32'd0);
        check("t5_coef",       32'(coef),       32'd0);
        check("t5_rej_cnt",    32'(rej_cnt),    32'd0);
        check("t5_fifo_clr",   32'(fifo_clr),   32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_idle_clr", 32'(fifo_clr), 32'd0);

        // T5 restart + T6: start ignored in RUN, honoured in DONE
        got_coef.delete();
        got_idx.delete();
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_data  = BUNDLE_A;
        in_valid = 1'b1;
        cyc(20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_run_start_no_clr", 32'(fifo_clr), 32'd0);
        check("t6_run_start_busy", 32'(busy), 32'd1);
        wait_done();
        check("t6_done", 32'(done), 32'd1);
        check("t6_done_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_done_start_clr", 32'(fifo_clr), 32'd1);
        check("t6_done_start_busy", 32'(busy), 32'd1);
        check("t6_done_dropped", 32'(done), 32'd0);
        @(negedge clk);
        check("t6_clr_one_cycle", 32'(fifo_clr), 32'd0);
        check_full_run("t6");
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
